// File: rtl/n64_flashram_pkg.sv
// Shared types and constants for the FlashRAM register-side emulator.
package n64_flashram_pkg;

    typedef enum logic [1:0] {
        MODE_STATUS = 2'd0,
        MODE_READ   = 2'd1,
        MODE_BUFFER = 2'd2,
        MODE_BUSY   = 2'd3
    } e_flashram_mode;

    // Encoding doubles as the op_type value handed to firmware
    typedef enum logic [1:0] {
        OP_SECTOR_ERASE = 2'd0,
        OP_CHIP_ERASE   = 2'd1,
        OP_PROGRAM      = 2'd2,
        OP_NONE         = 2'd3
    } e_flashram_op;

    localparam logic [7:0]  CMD_SECTOR_ERASE = 8'h4B;
    localparam logic [7:0]  CMD_CHIP_ERASE   = 8'h3C;
    localparam logic [7:0]  CMD_BUFFER       = 8'hB4;
    localparam logic [7:0]  CMD_SET_PAGE     = 8'hA5;
    localparam logic [7:0]  CMD_EXECUTE      = 8'hD2;
    localparam logic [7:0]  CMD_STATUS       = 8'hE1;
    localparam logic [7:0]  CMD_READ         = 8'hF0;

    localparam logic [15:0] STATUS_HI        = 16'h1111;
    localparam logic [7:0]  STATUS_LO_ID     = 8'h80;

endpackage

// File: rtl/n64_flashram_if.sv
// PI register-bus window into the FlashRAM emulator.
interface n64_flashram_if;

    logic        select;
    logic        read;
    logic        write;
    logic [16:0] address;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (
        output select, read, write, address, wdata,
        input  rdata
    );

    modport slave (
        input  select, read, write, address, wdata,
        output rdata
    );

endinterface

// File: rtl/n64_flashram.sv
// FlashRAM save emulator: command decode, mode tracking, status reads,
// page-buffer write steering and erase/program job hand-off to firmware.
module n64_flashram
    import n64_flashram_pkg::*;
#(
    parameter int unsigned PAGE_BITS    = 10,
    parameter int unsigned SECTOR_SHIFT = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enabled,
    input  logic                 i_n64_reset,
    n64_flashram_if.slave        bus,
    output logic                 o_read_mode,
    output logic                 o_buffer_write,
    output logic [5:0]           o_buffer_address,
    output logic [15:0]          o_buffer_wdata,
    output logic                 o_op_start,
    output logic [1:0]           o_op_type,
    output logic [PAGE_BITS-1:0] o_op_page,
    input  logic                 i_op_done
);

    e_flashram_mode       r_mode,      w_mode;
    e_flashram_op         r_pending,   w_pending;
    e_flashram_op         r_job,       w_job;
    logic [PAGE_BITS-1:0] r_page,      w_page;
    logic [PAGE_BITS-1:0] r_op_page,   w_op_page;
    logic [15:0]          r_cmd_hi,    w_cmd_hi;
    // {erase_done, program_done, erase_busy, program_busy}
    logic [3:0]           r_status,    w_status;
    logic                 r_op_start,  w_op_start;
    logic                 r_buf_write, w_buf_write;
    logic [5:0]           r_buf_addr,  w_buf_addr;
    logic [15:0]          r_buf_wdata, w_buf_wdata;

    logic       w_cmd_wr;
    logic       w_data_wr;
    logic [7:0] w_cmd;
    logic       w_read_mode;
    logic       w_unused_bits;

    assign w_cmd_wr  = bus.select & bus.write &  bus.address[16] & i_enabled;
    assign w_data_wr = bus.select & bus.write & ~bus.address[16] & i_enabled;
    assign w_cmd     = r_cmd_hi[15:8];

    assign w_unused_bits = ^{bus.address[15:7], bus.address[0], r_cmd_hi[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= MODE_STATUS;
            r_pending   <= OP_NONE;
            r_job       <= OP_SECTOR_ERASE;
            r_page      <= '0;
            r_op_page   <= '0;
            r_cmd_hi    <= '0;
            r_status    <= '0;
            r_op_start  <= 1'b0;
            r_buf_write <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
        end else begin
            r_mode      <= w_mode;
            r_pending   <= w_pending;
            r_job       <= w_job;
            r_page      <= w_page;
            r_op_page   <= w_op_page;
            r_cmd_hi    <= w_cmd_hi;
            r_status    <= w_status;
            r_op_start  <= w_op_start;
            r_buf_write <= w_buf_write;
            r_buf_addr  <= w_buf_addr;
            r_buf_wdata <= w_buf_wdata;
        end
    end

    always_comb begin
        w_mode      = r_mode;
        w_pending   = r_pending;
        w_job       = r_job;
        w_page      = r_page;
        w_op_page   = r_op_page;
        w_cmd_hi    = r_cmd_hi;
        w_status    = r_status;
        w_op_start  = 1'b0;
        w_buf_write = 1'b0;
        w_buf_addr  = r_buf_addr;
        w_buf_wdata = r_buf_wdata;

        if (r_mode == MODE_BUSY) begin
            // A running job ignores commands, enable and console reset; only op_done ends it
            if (i_op_done) begin
                w_mode = MODE_STATUS;
                if (r_job == OP_PROGRAM) begin
                    w_status[0] = 1'b0;
                    w_status[2] = 1'b1;
                end else begin
                    w_status[1] = 1'b0;
                    w_status[3] = 1'b1;
                end
            end
            if (i_n64_reset) begin
                w_pending = OP_NONE;
                w_cmd_hi  = '0;
            end else if (w_cmd_wr && !bus.address[1]) begin
                w_cmd_hi = bus.wdata;
            end
        end else if (i_n64_reset) begin
            // Console reset wins over any bus write in the same cycle
            w_mode    = MODE_STATUS;
            w_pending = OP_NONE;
            w_cmd_hi  = '0;
        end else if (!i_enabled) begin
            w_mode = MODE_STATUS;
        end else begin
            if (w_cmd_wr) begin
                if (!bus.address[1]) begin
                    w_cmd_hi = bus.wdata;
                end else begin
                    case (w_cmd)
                        CMD_SECTOR_ERASE: begin
                            w_pending = OP_SECTOR_ERASE;
                            w_page    = {bus.wdata[PAGE_BITS-1:SECTOR_SHIFT],
                                         {SECTOR_SHIFT{1'b0}}};
                        end
                        CMD_CHIP_ERASE: begin
                            w_pending = OP_CHIP_ERASE;
                            w_page    = '0;
                        end
                        CMD_BUFFER: begin
                            w_mode    = MODE_BUFFER;
                            w_pending = OP_PROGRAM;
                        end
                        CMD_SET_PAGE: begin
                            w_page = bus.wdata[PAGE_BITS-1:0];
                        end
                        CMD_EXECUTE: begin
                            if (r_pending != OP_NONE) begin
                                w_op_start = 1'b1;
                                w_job      = r_pending;
                                w_op_page  = (r_pending == OP_CHIP_ERASE) ? '0 : r_page;
                                w_mode     = MODE_BUSY;
                                w_pending  = OP_NONE;
                                w_status   = (r_pending == OP_PROGRAM) ? 4'b0001 : 4'b0010;
                            end
                        end
                        CMD_STATUS: w_mode = MODE_STATUS;
                        CMD_READ:   w_mode = MODE_READ;
                        default: ;
                    endcase
                end
            end
            if (w_data_wr && r_mode == MODE_BUFFER) begin
                w_buf_write = 1'b1;
                w_buf_addr  = bus.address[6:1];
                w_buf_wdata = bus.wdata;
            end
        end
    end

    always_comb begin
        w_read_mode = (r_mode == MODE_READ) && i_enabled;
        bus.rdata   = '0;
        if (bus.select && bus.read && !bus.address[16] && !w_read_mode) begin
            bus.rdata = bus.address[1] ? {STATUS_LO_ID, 4'h0, r_status} : STATUS_HI;
        end
    end

    assign o_read_mode      = w_read_mode;
    assign o_buffer_write   = r_buf_write;
    assign o_buffer_address = r_buf_addr;
    assign o_buffer_wdata   = r_buf_wdata;
    assign o_op_start       = r_op_start;
    assign o_op_type        = r_job;
    assign o_op_page        = r_op_page;

endmodule
